// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - single-command bus sequencer driving per-register LDBUS/WR/INC/CLR strobes
// Only this block drives LDBUS; all strobes decode from registered state and latched command fields.
module bus_xfer_ctrl #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int SELW = 3
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [SELW-1:0] req_src,
  input  logic [SELW-1:0] req_dst,
  input  logic [DW-1:0]   req_imm,
  input  logic [DW-1:0]   bus_in,
  output logic [DW-1:0]   bin_out,
  output logic [NREG-1:0] ldbus,
  output logic [NREG-1:0] wr,
  output logic [NREG-1:0] inc,
  output logic [NREG-1:0] clr,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WRITE  = 3'd2,
    S_SINGLE = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  localparam logic [1:0]      OP_MOVE = 2'b00;
  localparam logic [1:0]      OP_CLR  = 2'b10;
  localparam logic [1:0]      OP_LDI  = 2'b11;
  localparam logic [SELW:0]   W_NREG  = (SELW+1)'(NREG);
  localparam logic [NREG-1:0] ONE     = NREG'(1);

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_op;
  logic [SELW-1:0] r_src;
  logic [SELW-1:0] r_dst;
  logic [DW-1:0]   r_hold;
  logic            w_accept;
  logic            w_illegal;
  logic [NREG-1:0] w_src_oh;
  logic [NREG-1:0] w_dst_oh;

  assign req_ready = (r_state == S_IDLE) && !RST;
  assign w_accept  = req_valid && req_ready;
  // The source index only matters for MOVE; other ops may carry any src.
  assign w_illegal = ({1'b0, req_dst} >= W_NREG) ||
                     ((req_op == OP_MOVE) && ({1'b0, req_src} >= W_NREG));

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (!w_accept) begin
          w_next = S_IDLE;
        end else if (w_illegal) begin
          w_next = S_ERR;
        end else begin
          case (req_op)
            OP_MOVE: w_next = S_LOAD;
            OP_LDI:  w_next = S_WRITE;
            default: w_next = S_SINGLE;
          endcase
        end
      end
      S_LOAD:  w_next = S_WRITE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_op   <= '0;
      r_src  <= '0;
      r_dst  <= '0;
      r_hold <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= req_op;
        r_src <= req_src;
        r_dst <= req_dst;
      end
      if (w_accept && !w_illegal && (req_op == OP_LDI)) begin
        r_hold <= req_imm;
      end else if (r_state == S_LOAD) begin
        r_hold <= bus_in;
      end
    end
  end

  assign w_src_oh = ONE << r_src;
  assign w_dst_oh = ONE << r_dst;
  assign bin_out  = r_hold;

  always_comb begin
    ldbus = '0;
    wr    = '0;
    inc   = '0;
    clr   = '0;
    busy  = (r_state != S_IDLE);
    done  = 1'b0;
    err   = 1'b0;
    case (r_state)
      S_LOAD: ldbus = w_src_oh;
      S_WRITE: begin
        wr   = w_dst_oh;
        done = 1'b1;
      end
      S_SINGLE: begin
        if (r_op == OP_CLR) begin
          clr = w_dst_oh;
        end else begin
          inc = w_dst_oh;
        end
        done = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

endmodule
